// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the 4-bit CPU instruction sequencer.
//   - default address/instruction widths
//   - opcode and sequencer state enumerations
//   - ALU operation encodings
//   - strobe bundle passed from the decoder to the sequencer
package ctrl_pkg;

    localparam int AW_DEF = 4;
    localparam int IW_DEF = 8;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_ADDI = 4'h2,
        OP_SUBI = 4'h3,
        OP_OUT  = 4'h4,
        OP_JMP  = 4'h5,
        OP_JC   = 4'h6,
        OP_JZ   = 4'h7,
        OP_HLT  = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    // Everything the decoder produces for one EXEC cycle.
    typedef struct packed {
        logic       pc_en;
        logic       jump;
        logic       acc_we;
        logic [1:0] alu_op;
        logic       out_we;
        logic       flag_ld_alu;  // flags take alu_carry/alu_zero
        logic       flag_ld_imm;  // flags take (imm==0, carry=0)
        logic       halt_req;     // leave EXEC for HALT
    } strobes_t;

endpackage

// File: rtl/ctrl_if.sv
// ctrl_if: bundle between the sequencer and the rest of the core.
//   instr               ROM word for the current program counter
//   alu_carry/alu_zero  ALU status for the operation currently strobed
//   pc_en/jump/target   program counter control
//   acc_we/alu_op/imm   accumulator / ALU control
//   out_we              output-port write strobe
//   halted              core stopped
// Modports: master = sequencer side, slave = datapath side.
interface ctrl_if #(
    parameter int AW = ctrl_pkg::AW_DEF,
    parameter int IW = ctrl_pkg::IW_DEF
) ();

    logic [IW-1:0] instr;
    logic          alu_carry;
    logic          alu_zero;
    logic          pc_en;
    logic          jump;
    logic [AW-1:0] target;
    logic          acc_we;
    logic [1:0]    alu_op;
    logic [AW-1:0] imm;
    logic          out_we;
    logic          halted;

    modport master (
        input  instr, alu_carry, alu_zero,
        output pc_en, jump, target, acc_we, alu_op, imm, out_we, halted
    );

    modport slave (
        output instr, alu_carry, alu_zero,
        input  pc_en, jump, target, acc_we, alu_op, imm, out_we, halted
    );

endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational instruction decode.
//   exec   sequencer is in EXEC (all strobes are gated by it)
//   ir     latched instruction word
//   carry  carry flag as held at the start of EXEC
//   zero   zero flag as held at the start of EXEC
//   st     strobe bundle for this cycle
// Build option CTRL_COND_JUMP_EN: when defined, JC/JZ branch on the flags;
// when undefined, opcodes 0x6/0x7 decode as NOP.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int IW = IW_DEF
) (
    input  logic          exec,
    input  logic [IW-1:0] ir,
    input  logic          carry,
    input  logic          zero,
    output strobes_t      st
);

    logic [3:0] op;

    assign op = ir[IW-1:AW];

    always_comb begin
        st = '0;
        if (exec) begin
            st.pc_en = 1'b1;
            case (op)
                OP_LDI: begin
                    st.acc_we      = 1'b1;
                    st.alu_op      = ALU_PASS;
                    st.flag_ld_imm = 1'b1;
                end
                OP_ADDI: begin
                    st.acc_we      = 1'b1;
                    st.alu_op      = ALU_ADD;
                    st.flag_ld_alu = 1'b1;
                end
                OP_SUBI: begin
                    st.acc_we      = 1'b1;
                    st.alu_op      = ALU_SUB;
                    st.flag_ld_alu = 1'b1;
                end
                OP_OUT: st.out_we = 1'b1;
                OP_JMP: st.jump   = 1'b1;
`ifdef CTRL_COND_JUMP_EN
                OP_JC:  st.jump   = carry;
                OP_JZ:  st.jump   = zero;
`endif
                OP_HLT: begin
                    // PC must stay on the HLT address.
                    st.pc_en    = 1'b0;
                    st.halt_req = 1'b1;
                end
                default: ;  // NOP, unused opcodes
            endcase
        end
    end

`ifndef CTRL_COND_JUMP_EN
    // Flags are unused by the decode in this build.
    logic unused_flags;
    assign unused_flags = carry ^ zero;
`endif

endmodule

// File: rtl/ctrl_unit.sv
// ctrl_unit: two-cycle FETCH/EXEC instruction sequencer for the 4-bit core.
//   clk   clock, rising edge
//   nrst  synchronous active-low reset
//   bus   ctrl_if master: instr/alu status in, PC/ALU/port strobes out
// Owns the state register, instruction register (ir) and carry/zero flags;
// strobe decode lives in ctrl_decode. All outputs are decoded from
// registered state only (no combinational path from instr).
// Build option CTRL_COND_JUMP_EN enables the JC/JZ conditional jumps.
module ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int IW = IW_DEF
) (
    input  logic  clk,
    input  logic  nrst,
    ctrl_if.master bus
);

    state_t        state_q, state_d;
    logic [IW-1:0] ir_q;
    logic          carry_q;
    logic          zero_q;
    logic          exec;
    strobes_t      st;

    assign exec = (state_q == ST_EXEC);

    ctrl_decode #(
        .AW (AW),
        .IW (IW)
    ) u_decode (
        .exec  (exec),
        .ir    (ir_q),
        .carry (carry_q),
        .zero  (zero_q),
        .st    (st)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC:  state_d = st.halt_req ? ST_HALT : ST_FETCH;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            ir_q <= '0;
        end else if (state_q == ST_FETCH) begin
            ir_q <= bus.instr;
        end
    end

    // Flags change only at the end of EXEC; reset wins, so a pending
    // update is dropped when nrst is low on that edge.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (st.flag_ld_alu) begin
            carry_q <= bus.alu_carry;
            zero_q  <= bus.alu_zero;
        end else if (st.flag_ld_imm) begin
            carry_q <= 1'b0;
            zero_q  <= (ir_q[AW-1:0] == '0);
        end
    end

    assign bus.pc_en  = st.pc_en;
    assign bus.jump   = st.jump;
    assign bus.acc_we = st.acc_we;
    assign bus.alu_op = st.alu_op;
    assign bus.out_we = st.out_we;
    assign bus.target = ir_q[AW-1:0];
    assign bus.imm    = ir_q[AW-1:0];
    assign bus.halted = (state_q == ST_HALT);

endmodule

// File: doc/ctrl_unit.md
# ctrl_unit

Instruction sequencer for the 4-bit CPU core. It accepts the 8-bit instruction word that program ROM returns for the current program counter address. It decodes the word and drives the counter's step, jump and target inputs, plus the accumulator/ALU/output-port strobes. It holds the carry and zero flags used for conditional branches and runs a two-cycle FETCH/EXEC sequence per instruction.

## Interface
- AW, 4, program address width; also width of the immediate and jump target
- IW, 8, instruction width; opcode = instr[IW-1:AW], immediate = instr[AW-1:0]
- clk  input  1  sole clock, rising edge
- nrst  input  1  reset, synchronous, active-low: sampled on rising clk edge only
- instr  input  IW  ROM data for the current program counter address, valid throughout FETCH
- alu_carry  input  1  ALU carry/borrow out for the operation currently strobed
- alu_zero  input  1  ALU result == 0 for the operation currently strobed
- pc_en  output  1  program counter advances (or jumps) at the next edge
- jump  output  1  with pc_en: load target instead of incrementing
- target  output  AW  jump destination (= immediate)
- acc_we  output  1  accumulator write strobe
- alu_op  output  2  00 pass immediate, 01 add, 10 subtract
- imm  output  AW  immediate operand
- out_we  output  1  output-port write strobe (port latches accumulator)
- halted  output  1  core stopped

## Operation
- Opcodes: 0x0 NOP, 0x1 LDI, 0x2 ADDI, 0x3 SUBI, 0x4 OUT, 0x5 JMP, 0x6 JC, 0x7 JZ, 0xF HLT. Opcodes 0x8–0xE decode as NOP.
- States: FETCH -> EXEC -> FETCH. From EXEC, HLT goes to HALT. HALT is left only by reset.
- FETCH: latch instr into the internal instruction register (ir). All strobes are low.
- EXEC: outputs are decoded from ir. pc_en=1 for exactly this cycle. All other strobes are asserted only in EXEC.
- LDI: acc_we=1, alu_op=00. Zero flag = (imm==0), carry flag cleared.
- ADDI/SUBI: acc_we=1, alu_op=01/10. Carry and zero flags load alu_carry and alu_zero at the end of EXEC.
- OUT: out_we=1. Flags are unchanged.
- JMP: jump=1. JC: jump=carry flag. JZ: jump=zero flag. Conditional jumps use the flag values held at the start of EXEC.
- target and imm always equal ir[AW-1:0] and may toggle freely outside strobes.
- HLT: pc_en=0 in its EXEC cycle, so the program counter stays on the HLT address. halted=1 from the next cycle on. No strobes while halted.

## Timing
- Reset (nrst low at a rising edge) sets: state FETCH, ir=0, flags=0, and every output 0, including halted.
- Reset mid-EXEC takes effect on that edge. The pending instruction's strobes and flag updates are discarded.
- Throughput: one instruction per 2 cycles. Latency from instr valid in FETCH to its strobes is 1 cycle.
- Strobes are Moore-style (decoded from state and ir), with no combinational path from instr. The flag update path is alu_* -> flag registers.
- Back-to-back flag write then conditional jump (e.g. SUBI then JZ) sees the updated flag, because at least one FETCH cycle separates them.
- Address wrap-around (jump or step past 2^AW-1) is the counter's concern. This block imposes no restriction.

## Configuration
- CTRL_COND_JUMP_EN defined: JC and JZ behave as specified.
- CTRL_COND_JUMP_EN undefined: 0x6 and 0x7 decode as NOP (pc_en=1, jump=0). The flag registers still update, since they are visible to a future status read.

## Structure
- Package ctrl_pkg holds:
  - the opcode enum (4-bit) and state enum (FETCH, EXEC, HALT);
  - the alu_op encodings;
  - the AW and IW defaults.
- One sub-module, ctrl_decode: purely combinational decode from ir and flags to the strobe set. ctrl_unit owns the FSM, ir and flags.

## Test plan
- Reset with instr=0x13, then release nrst -> first EXEC (cycle 2): acc_we=1, alu_op=00, imm=3, pc_en=1, jump=0, zero flag=0.
- LDI 0, then JZ 9 (0x79) -> EXEC of JZ: pc_en=1, jump=1, target=9. With CTRL_COND_JUMP_EN undefined: jump=0.
- SUBI 1 with alu_carry=1, alu_zero=0, then JC 4 (0x64) -> jump=1, target=4. Repeat with alu_carry=0 -> jump=0.
- OUT (0x40) -> out_we=1 for exactly one cycle, acc_we=0, flags unchanged.
- HLT (0xF0) -> pc_en=0 in its EXEC, halted=1 thereafter, no strobes for 10 cycles. Then nrst low for one edge -> halted=0, state FETCH.
- Assert nrst low during the EXEC of ADDI -> flags stay 0 and all outputs are 0 at the next cycle.
